spec_remap_stream: RTL

- Parametrised spectral bin remapper for the voice-change path. Sits between the FFT-bin RAM and the IFFT input stream.
- On each start it produces one frame of N = 2^N_LOG2 bins. The bin order comes from a runtime pitch ratio instead of a fixed ROM table.
- The upper half of the frame is rebuilt as the Hermitian mirror of the lower half, so the IFFT output stays real.
- Adds output backpressure (ready/valid), selectable modes and a busy flag.

---
 rtl/spec_remap_pkg.sv | 20 ++
 rtl/spec_remap_fifo.sv | 56 +++++
 rtl/spec_remap_stream.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/spec_remap_pkg.sv
// Shared encodings for the spectral bin remapper: mode codes, Q4.8 constants
// and the frame-control state machine states.
package spec_remap_pkg;

   localparam logic [1:0] MODE_BYPASS      = 2'd0;
   localparam logic [1:0] MODE_SHIFT       = 2'd1;
   localparam logic [1:0] MODE_SHIFT_LOWER = 2'd2;
   localparam logic [1:0] MODE_MUTE        = 2'd3;

   localparam int unsigned Q48_UNITY = 32'd256;
   localparam int unsigned Q48_ROUND = 32'd128;
   localparam int unsigned Q48_FRAC  = 32'd8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

endpackage

// File: rtl/spec_remap_fifo.sv
// First-word-fall-through synchronous FIFO carrying {last, bin} beats,
// with an occupancy count used by the upstream credit check.
module spec_remap_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 33
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW:0]      count_r;
   logic             push_s;
   logic             pop_s;

   // Guarded push/pop so a misbehaving neighbour can never corrupt the pointers.
   always_comb begin
      push_s = wr_en && (count_r != (AW+1)'(DEPTH));
      pop_s  = rd_en && (count_r != {(AW+1){1'b0}});
   end

   // Storage, pointers and occupancy.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
            wr_ptr_r        <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         count_r <= count_r + (AW+1)'(push_s) - (AW+1)'(pop_s);
      end
   end

   assign rd_data = mem_r[rd_ptr_r];
   assign empty   = (count_r == {(AW+1){1'b0}});
   assign count   = count_r;

endmodule

// File: rtl/spec_remap_stream.sv
// Spectral bin remapper: streams one frame of N bins, reading the lower half
// at pitch-scaled addresses and rebuilding the upper half as its conjugate mirror.
module spec_remap_stream
   import spec_remap_pkg::*;
#(
   parameter int N_LOG2     = 10,
   parameter int HALF_W     = 16,
   parameter int RATIO_W    = 12,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [1:0]            mode,
   input  logic [RATIO_W-1:0]    ratio,
   output logic                  busy,
   output logic                  ram_rd_en,
   output logic [N_LOG2-1:0]     ram_addr,
   input  logic [2*HALF_W-1:0]   ram_data,
   output logic [2*HALF_W-1:0]   out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last
);
   localparam int N  = 1 << N_LOG2;
   localparam int H  = N / 2;
   localparam int PW = N_LOG2 + RATIO_W;
   localparam int SW = PW + 1 - Q48_FRAC;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int DW = 2 * HALF_W;

   function automatic logic [HALF_W-1:0] neg_sat(input logic [HALF_W-1:0] v);
      if (v == {1'b1, {(HALF_W-1){1'b0}}}) begin
         return {1'b0, {(HALF_W-1){1'b1}}};
      end else begin
         return -v;
      end
   endfunction

   state_e              state_r, state_s;
   logic                busy_r, busy_s;
   logic [1:0]          mode_r;
   logic [RATIO_W-1:0]  ratio_r;
   logic [N_LOG2-1:0]   k_r;
   logic                accept_s, issue_s, pop_s;
   logic [CW:0]         occ_s;
   logic [CW-1:0]       fifo_count_s;
   logic                fifo_empty_s;
   logic [DW:0]         fifo_wr_data_s, fifo_rd_data_s;

   logic                upper_s;
   logic [N_LOG2-1:0]   m_s;
   logic [PW-1:0]       prod_s;
   logic [PW:0]         rnd_s;
   logic [SW-1:0]       s_s;
   logic [N_LOG2-1:0]   addr_s;
   logic                zero2_s;
   logic [HALF_W-1:0]   re_s, im_s;

   logic                v1_r, upper1_r, last1_r;
   logic [PW-1:0]       prod1_r;
   logic                v2_r, upper2_r, zero2_r, last2_r;
   logic                rd_en_r;
   logic [N_LOG2-1:0]   addr_r;
   logic                v3_r, upper3_r, zero3_r, last3_r;

   // Frame FSM; the credit check counts FIFO entries plus every pipeline slot, less the beat leaving now.
   always_comb begin
      occ_s    = (CW+1)'(fifo_count_s) + (CW+1)'(v1_r) + (CW+1)'(v2_r) + (CW+1)'(v3_r);
      pop_s    = out_valid & out_ready;
      accept_s = 1'b0;
      issue_s  = 1'b0;
      state_s  = state_r;
      busy_s   = busy_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               accept_s = 1'b1;
               state_s  = ST_RUN;
               busy_s   = 1'b1;
            end else begin
               state_s  = ST_IDLE;
            end
         end
         ST_RUN: begin
            if ((occ_s - (CW+1)'(pop_s)) < (CW+1)'(FIFO_DEPTH)) begin
               issue_s = 1'b1;
               if (k_r == N_LOG2'(N-1)) begin
                  state_s = ST_DRAIN;
               end else begin
                  state_s = ST_RUN;
               end
            end else begin
               issue_s = 1'b0;
            end
         end
         ST_DRAIN: begin
            if (pop_s && out_last) begin
               state_s = ST_IDLE;
               busy_s  = 1'b0;
            end else begin
               state_s = ST_DRAIN;
            end
         end
         default: begin
            state_s = ST_IDLE;
            busy_s  = 1'b0;
         end
      endcase
   end

   // Control registers; bypass is folded into a unity ratio so one datapath serves every mode.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         busy_r  <= 1'b0;
         mode_r  <= MODE_BYPASS;
         ratio_r <= '0;
         k_r     <= '0;
      end else begin
         state_r <= state_s;
         busy_r  <= busy_s;
         if (accept_s) begin
            mode_r  <= mode;
            ratio_r <= (mode == MODE_BYPASS) ? RATIO_W'(Q48_UNITY) : ratio;
            k_r     <= '0;
         end else if (issue_s) begin
            k_r <= k_r + N_LOG2'(1);
         end
      end
   end

   // Index mapping: fold upper bins onto the lower half, then scale, round and range-check.
   always_comb begin
      upper_s = (k_r > N_LOG2'(H));
      m_s     = upper_s ? (N_LOG2'(0) - k_r) : k_r;
      prod_s  = PW'(m_s) * PW'(ratio_r);
      rnd_s   = {1'b0, prod1_r} + (PW+1)'(Q48_ROUND);
      s_s     = SW'(rnd_s >> Q48_FRAC);
      addr_s  = upper1_r ? (N_LOG2'(0) - s_s[N_LOG2-1:0]) : s_s[N_LOG2-1:0];
      zero2_s = (mode_r == MODE_MUTE) || ((mode_r == MODE_SHIFT_LOWER) && upper1_r)
                || (s_s > SW'(H));
   end

   // Slot pipeline; tags ride alongside so stage 3 lines up with the RAM return.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         {v1_r, upper1_r, last1_r} <= 3'b000;
         prod1_r                   <= '0;
         {v2_r, upper2_r, zero2_r, last2_r, rd_en_r} <= 5'b00000;
         addr_r                    <= '0;
         {v3_r, upper3_r, zero3_r, last3_r} <= 4'b0000;
      end else begin
         v1_r     <= issue_s;
         prod1_r  <= prod_s;
         upper1_r <= upper_s;
         last1_r  <= (k_r == N_LOG2'(N-1));
         v2_r     <= v1_r;
         rd_en_r  <= v1_r & ~zero2_s;
         addr_r   <= v1_r ? addr_s : addr_r;
         upper2_r <= upper1_r;
         zero2_r  <= zero2_s;
         last2_r  <= last1_r;
         v3_r     <= v2_r;
         upper3_r <= upper2_r;
         zero3_r  <= zero2_r;
         last3_r  <= last2_r;
      end
   end

   // Data stage: conjugate mirrored bins and blank muted or out-of-range ones.
   always_comb begin
      re_s = ram_data[DW-1:HALF_W];
      im_s = ram_data[HALF_W-1:0];
      if (zero3_r) begin
         fifo_wr_data_s = {last3_r, {DW{1'b0}}};
      end else if (upper3_r) begin
         fifo_wr_data_s = {last3_r, re_s, neg_sat(im_s)};
      end else begin
         fifo_wr_data_s = {last3_r, re_s, im_s};
      end
   end

   spec_remap_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DW + 1)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (v3_r),
      .wr_data (fifo_wr_data_s),
      .rd_en   (pop_s),
      .rd_data (fifo_rd_data_s),
      .empty   (fifo_empty_s),
      .count   (fifo_count_s)
   );

   assign busy      = busy_r;
   assign ram_rd_en = rd_en_r;
   assign ram_addr  = addr_r;
   assign out_valid = ~fifo_empty_s;
   assign out_last  = fifo_rd_data_s[DW];
   assign out_data  = fifo_rd_data_s[DW-1:0];

endmodule
